// File: rtl/md5_pkg.sv
// ============================================================================
// md5_pkg : shared types, constants and message-index mapping for MD5 control
// Revision : 1.0
// ============================================================================
`default_nettype none

package md5_pkg;

  localparam int NUM_STEPS = 64;
  localparam int MSG_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ROUND  = 3'd2,
    OUTPUT = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef logic [1:0] round_t;

  // g depends only on j mod 16 within each round, so 4-bit arithmetic is exact
  function automatic logic [3:0] md5_msg_index(input logic [5:0] j);
    logic [3:0] j_lo;
    logic [3:0] g;
    j_lo = j[3:0];
    case (j[5:4])
      2'd0:    g = j_lo;
      2'd1:    g = (j_lo * 4'd5) + 4'd1;
      2'd2:    g = (j_lo * 4'd3) + 4'd5;
      default: g = j_lo * 4'd7;
    endcase
    return g;
  endfunction

endpackage

`default_nettype wire

// File: rtl/md5_round_controller_if.sv
// ============================================================================
// md5_round_controller_if : handshake and datapath-control bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface md5_round_controller_if;
  import md5_pkg::*;

  logic                 start;
  logic                 msg_ready;
  logic [MSG_IDX_W-1:0] msg_idx;
  logic [5:0]           j;
  round_t               Fsel;
  logic [1:0]           Rsel;
  logic                 ld_a;
  logic                 ld_b;
  logic                 ld_c;
  logic                 ld_d;
  logic                 sel_a;
  logic                 sel_b;
  logic                 sel_c;
  logic                 sel_d;
  logic                 busy;
  logic                 hash_valid;
  logic [1:0]           hash_idx;
  logic                 done;

  modport master (
    output start, msg_ready,
    input  msg_idx, j, Fsel, Rsel,
    input  ld_a, ld_b, ld_c, ld_d,
    input  sel_a, sel_b, sel_c, sel_d,
    input  busy, hash_valid, hash_idx, done
  );

  modport slave (
    input  start, msg_ready,
    output msg_idx, j, Fsel, Rsel,
    output ld_a, ld_b, ld_c, ld_d,
    output sel_a, sel_b, sel_c, sel_d,
    output busy, hash_valid, hash_idx, done
  );

endinterface

`default_nettype wire

// File: rtl/md5_msg_index_gen.sv
// ============================================================================
// md5_msg_index_gen : combinational step index j -> message word index g
// Revision : 1.0
// ============================================================================
`default_nettype none

module md5_msg_index_gen
  import md5_pkg::*;
#(
  parameter int MSG_IDX_W = 4
) (
  input  logic [5:0]           j,
  output logic [MSG_IDX_W-1:0] g
);

  assign g = MSG_IDX_W'(md5_msg_index(j));

endmodule

`default_nettype wire

// File: rtl/md5_round_controller.sv
// ============================================================================
// md5_round_controller : sequences IV load, 64 MD5 steps and digest readout
// Revision : 1.0
// ============================================================================
`default_nettype none

module md5_round_controller
  import md5_pkg::*;
#(
  parameter int NUM_STEPS = md5_pkg::NUM_STEPS,
  parameter int MSG_IDX_W = md5_pkg::MSG_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  md5_round_controller_if.slave  bus
);

  localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);

  state_e               state_q;
  state_e               state_d;
  logic [5:0]           j_q;
  logic [5:0]           j_d;
  logic [1:0]           k_q;
  logic [1:0]           k_d;

  logic                 ld_all;
  logic                 sel_all;
  round_t               fsel;
  logic [1:0]           rsel;
  logic                 busy;
  logic                 hash_valid;
  logic [1:0]           hash_idx;
  logic                 done;
  logic [MSG_IDX_W-1:0] msg_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= 6'd0;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
    end
  end

  // j saturates at the last step; only INIT brings it back to zero
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = INIT;
      end
      INIT: begin
        j_d     = 6'd0;
        state_d = ROUND;
      end
      ROUND: begin
        if (bus.msg_ready) begin
          if (j_q == LAST_STEP) begin
            k_d     = 2'd0;
            state_d = OUTPUT;
          end else begin
            j_d = j_q + 6'd1;
          end
        end
      end
      OUTPUT: begin
        if (k_q == 2'd3) state_d = DONE;
        else             k_d     = k_q + 2'd1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ld_all     = 1'b0;
    sel_all    = 1'b0;
    fsel       = 2'd0;
    rsel       = 2'd0;
    busy       = 1'b0;
    hash_valid = 1'b0;
    hash_idx   = 2'd0;
    done       = 1'b0;
    case (state_q)
      INIT: begin
        ld_all  = 1'b1;
        sel_all = 1'b1;
        busy    = 1'b1;
      end
      ROUND: begin
        ld_all = bus.msg_ready;
        fsel   = j_q[5:4];
        busy   = 1'b1;
      end
      OUTPUT: begin
        busy       = 1'b1;
        hash_valid = 1'b1;
        hash_idx   = k_q;
        rsel       = ~k_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        ld_all = 1'b0;
      end
    endcase
  end

  md5_msg_index_gen #(
    .MSG_IDX_W (MSG_IDX_W)
  ) u_msg_index_gen (
    .j (j_q),
    .g (msg_idx)
  );

  assign bus.msg_idx    = msg_idx;
  assign bus.j          = j_q;
  assign bus.Fsel       = fsel;
  assign bus.Rsel       = rsel;
  assign bus.ld_a       = ld_all;
  assign bus.ld_b       = ld_all;
  assign bus.ld_c       = ld_all;
  assign bus.ld_d       = ld_all;
  assign bus.sel_a      = sel_all;
  assign bus.sel_b      = sel_all;
  assign bus.sel_c      = sel_all;
  assign bus.sel_d      = sel_all;
  assign bus.busy       = busy;
  assign bus.hash_valid = hash_valid;
  assign bus.hash_idx   = hash_idx;
  assign bus.done       = done;

endmodule

`default_nettype wire

// File: doc/md5_round_controller.md
Name: md5_round_controller

Overview:
- FSM that sequences the MD5 compression datapath for one 512-bit block: loads the IV into the A/B/C/D registers, then runs 64 steps with the correct round function, step index and message-word index.
- After step 63, it walks Rsel through the four output words so the datapath's final adder presents A..D of the digest, one word per cycle.
- Sits between the top level (start/done, 16-word message buffer) and the DP control pins. It holds no hash data itself.

Parameters:
- NUM_STEPS, 64, steps per block. Fixed by the algorithm; any other value is unsupported.
- MSG_IDX_W, 4, width of the message-word address into the 16-word block buffer.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one block; sampled only in IDLE
- msg_ready  in  1  message buffer word at msg_idx is valid; low stalls ROUND
- msg_idx  out  4  word index g presented to the message buffer (drives DP Message via the buffer)
- j  out  6  step counter to DP LUT_K/LUT_S
- Fsel  out  2  round-function select, equal to j[5:4] in ROUND
- Rsel  out  2  output-word select: 3=A, 2=B, 1=C, 0=D
- ld_a, ld_b, ld_c, ld_d  out  1 each  register load enables
- sel_a, sel_b, sel_c, sel_d  out  1 each  1 = IV, 0 = round feedback
- busy  out  1  high from INIT through the last OUTPUT cycle
- hash_valid  out  1  DP HashResult holds a digest word this cycle
- hash_idx  out  2  digest word number: 0=A, 1=B, 2=C, 3=D
- done  out  1  one-cycle pulse after the last digest word

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state IDLE. All outputs are 0, including j, msg_idx, Fsel, Rsel, all ld_* and sel_*, busy, hash_valid, hash_idx and done.
- Reset asserted in any state returns to IDLE on the next edge. DP registers are not reloaded; the next start re-inits them.
- States are IDLE, INIT, ROUND, OUTPUT, DONE.
- IDLE: all ld_* = 0. On start=1, go to INIT. start is ignored in every other state.
- INIT (1 cycle): sel_* = 1 and ld_* = 1, loading the IV. j cleared to 0. Next state ROUND.
- ROUND, when msg_ready=1:
  - sel_* = 0 and ld_* = 1.
  - Fsel = j[5:4].
  - If j = 63, go to OUTPUT; otherwise j increments.
- ROUND, when msg_ready=0: ld_* = 0 and j holds (stall). Outputs stay stable, so DP register state is untouched.
- msg_idx is combinational from j, with the result mod 16:
  - j 0..15: g = j
  - j 16..31: g = (5j+1)
  - j 32..47: g = (3j+5)
  - j 48..63: g = 7j
- OUTPUT (4 cycles, counter k=0..3): ld_* = 0, hash_valid = 1, hash_idx = k, Rsel = 3-k. After k=3, go to DONE.
- DONE (1 cycle): done = 1, busy = 0. Next state IDLE. start in DONE is ignored.
- Latency with no stalls, where start is sampled at edge 0:
  - INIT in cycle 1
  - steps j=0..63 in cycles 2..65
  - digest words in cycles 66..69
  - done in cycle 70
- Each stall cycle adds exactly one cycle to this latency.
- j never wraps in operation; 63→0 occurs only via INIT.
- Outside ROUND, Fsel = 0. Outside OUTPUT, Rsel = 0 and hash_idx = 0.

Decomposition:
- Shared package md5_pkg holds:
  - state enum: IDLE, INIT, ROUND, OUTPUT, DONE
  - NUM_STEPS
  - round-number typedef (2 bits)
  - function md5_msg_index(j) returning 4 bits, so the bench and RTL share one definition
- One natural sub-module: md5_msg_index_gen, a combinational j→g mapper, kept separate for unit testing.
- The FSM and counters stay in md5_round_controller.

Test Plan:
- Reset behaviour: rst high for 2 cycles, then start → INIT at cycle 1 with all sel_* and ld_* = 1. ROUND starts with j=0, Fsel=0, msg_idx=0. done at cycle 70.
- Index mapping: run without stalls and check msg_idx against the expected values:
  - j=20 → 5
  - j=33 → 8
  - j=50 → 14
  - j=63 → 9
  - Fsel at j=16/32/48 is 1/2/3.
- Stall: drop msg_ready at j=10 for 3 cycles → j stays 10, ld_* = 0 for 3 cycles, and done is delayed to cycle 73.
- Integration with DP on the padded empty message (word0=0x00000080, others 0): hash_valid words in order 0xd98c1dd4, 0x04b2008f, 0x980980e9, 0x7e42f8ec, with hash_idx 0..3 and Rsel 3..0.
- Reset mid-ROUND at j=40 → next cycle IDLE with all outputs 0. A new start gives a correct digest.
- start held high through the whole operation and in DONE → exactly one block is processed per start seen in IDLE. A back-to-back start seen in IDLE after DONE begins a second block.
